execute_stage_mdu: RTL and testbench
====================================

# execute_stage_mdu

Parametrised execute stage for the 5-stage RISC-V pipeline, generalising the single-cycle execute stage. Adds full RV32 branch/jump resolution, a multi-cycle multiply/divide unit (MDU) with a stall handshake toward the hazard unit, and the E→M pipeline register with bubble insertion. It sits between the D/E register and the memory stage. It retains the 3:1 forwarding muxes on both operands.

## Interface
- XLEN, 32: datapath width.
- REGW, 5: register-index width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e  in  1 each  D/E control.
- result_src_e  in  2  result select, passed to M.
- alu_control_e  in  4  0–9 = ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA; 10–13 = MUL, MULH, DIV, REM.
- funct3_e  in  3  branch condition: BEQ/BNE/BLT/BGE/BLTU/BGEU.
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  in  XLEN  operands.
- rd_e  in  REGW  destination index.
- forward_a_e, forward_b_e  in  2  00 = regfile, 01 = result_w, 10 = alu_result_m.
- result_w  in  XLEN  writeback forwarding value.
- pc_src_e  out  1  redirect fetch (branch taken or jump).
- pc_target_e  out  XLEN  pc_e+imm, or (src_a+imm)&~1 when jalr_e.
- busy_o  out  1  MDU stall request; hazard unit freezes F, D and E.
- reg_write_m, mem_write_m  out  1  M control.
- result_src_m  out  2.
- rd_m  out  REGW.
- alu_result_m, write_data_m, pc_plus4_m  out  XLEN.

## Operation
- src_a = forward mux A; src_b_fwd = forward mux B; src_b = alu_src_e ? imm_ext_e : src_b_fwd.
- ALU ops are combinational. Shifts use src_b[log2(XLEN)-1:0]. SLT is signed; SLTU is unsigned.
- Branch compare is src_a vs src_b_fwd per funct3_e. pc_src_e = (branch_e & cond) | jump_e | jalr_e. It is combinational and asserted only when busy_o = 0.
- MDU FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: on ops 10–13, latch src_a/src_b into operand registers (forward sources may advance during the stall) and go to MUL (ops 10, 11) or DIV (ops 12, 13).
  - MUL: 1 cycle; computes the full 2·XLEN signed product, registered. Then DONE.
  - DIV: radix-2 restoring divide on magnitudes; XLEN iterations counted by a log2(XLEN)+1-bit counter; sign fix-up at exit. Then DONE.
  - DONE: the MDU result drives the ALU result mux; E→M loads normally; return to IDLE.
- busy_o = 1 in IDLE when an MDU op is present, and in MUL and DIV. It is 0 in DONE.
- While busy_o = 1, the E→M register loads a bubble: reg_write_m = mem_write_m = 0, result_src_m = 0, rd_m = 0, data fields 0.
- MUL returns product[XLEN-1:0]; MULH returns product[2XLEN-1:XLEN]. Both are signed.
- Divide by zero: quotient = all ones, remainder = dividend.
- Overflow (most-negative / −1): quotient = dividend, remainder = 0.
- write_data_m = src_b_fwd. pc_plus4_m = pc_plus4_e. alu_result_m = ALU or MDU result.

## Timing
- Reset: every M output = 0, FSM = IDLE, counter = 0, operand registers = 0. busy_o = 0 because E holds a bubble after reset.
- Reset mid-MDU operation aborts it on the same edge; no partial result reaches M.
- ALU op: 1 cycle E→M.
- MUL/MULH: busy_o high for 2 cycles; result in M 3 edges after entry.
- DIV/REM: busy_o high for XLEN+1 cycles; result in M after XLEN+2 edges.
- Back-to-back MDU ops: DONE→IDLE takes 1 cycle; the next op starts the cycle after DONE.
- Branch in E while busy_o = 0 is resolved the same cycle. F/D flush is the hazard unit's job; this block never flushes its own E→M.

## Configuration
- EXEC_MDU_EN defined: MDU, FSM and busy_o logic are present as above.
- EXEC_MDU_EN undefined: no MDU logic; ops 10–13 produce alu_result 0 in a single cycle; busy_o is tied to 0.

## Test plan
- ADD: rd1=5, rd2=7, alu_src=0 → after 1 edge alu_result_m=12, reg_write_m passes through.
- Forwarding: forward_a=10, alu_result_m=0x100, imm=4, ADD with alu_src=1 → next alu_result_m=0x104; forward_a=01 with result_w=3 → 7.
- BLT: src_a=−1, src_b=1 → pc_src_e=1, pc_target_e=pc_e+imm. BLTU with the same operands → pc_src_e=0. JALR: src_a=0x1003, imm=0 → target 0x1002.
- DIV: −7 / 2 → busy_o high 33 cycles, bubbles in M throughout, then alu_result_m=−3. REM of the same operands → −1. DIV by 0 → 0xFFFFFFFF.
- MULH: 0x80000000 × 0x80000000 → 0x40000000 after 3 edges. MUL: 0xFFFFFFFF × 2 → 0xFFFFFFFE.
- Assert rst mid-DIV (cycle 10) → next edge busy_o=0 and all M outputs 0. A new ADD then completes in 1 cycle.

Source files
------------

// File: rtl/execute_stage_mdu.sv
// rtl/execute_stage_mdu.sv - RV32 execute stage with branch resolution, optional multi-cycle MDU and E->M register
//
// Purpose:
//   Execute stage of the 5-stage pipeline. It contains:
//   - 3:1 forwarding muxes on both operands
//   - a combinational ALU (ops 0-9)
//   - branch/jump resolution
//   - an optional multiply/divide unit for ops 10-13 (MUL, MULH, DIV, REM)
//   - the E->M pipeline register, which loads a bubble while the MDU stalls
//
// Configuration:
//   EXEC_MDU_EN  When defined, the MDU FSM, its operand registers and busy_o
//                are built. When undefined, ops 10-13 return 0 in a single
//                cycle and busy_o is tied to 0.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   reg_write_e, mem_write_e          D/E control bits, passed to M
//   branch_e, jump_e, jalr_e          D/E control bits, used for redirect
//   alu_src_e                         operand B select (immediate)
//   result_src_e [1:0]                result select, passed to M
//   alu_control_e [3:0]               ALU / MDU operation
//   funct3_e [2:0]                    branch condition
//   rd1_e, rd2_e, imm_ext_e           operand values
//   pc_e, pc_plus4_e                  program counter values
//   rd_e [REGW-1:0]                   destination register index
//   forward_a_e, forward_b_e [1:0]    forwarding selects
//   result_w                          writeback forwarding value
//   pc_src_e, pc_target_e             fetch redirect request and target
//   busy_o                            MDU stall request to the hazard unit
//   reg_write_m, mem_write_m,
//   result_src_m, rd_m,
//   alu_result_m, write_data_m,
//   pc_plus4_m                        E->M register outputs

module execute_stage_mdu #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write_e,
    input  logic            mem_write_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            jalr_e,
    input  logic            alu_src_e,
    input  logic [1:0]      result_src_e,
    input  logic [3:0]      alu_control_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic [REGW-1:0] rd_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            busy_o,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [REGW-1:0] rd_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m
);

    localparam int SHW  = $clog2(XLEN);
    localparam int CNTW = SHW + 1;

    // E->M register
    logic            reg_write_m_q, reg_write_m_d;
    logic            mem_write_m_q, mem_write_m_d;
    logic [1:0]      result_src_m_q, result_src_m_d;
    logic [REGW-1:0] rd_m_q, rd_m_d;
    logic [XLEN-1:0] alu_result_m_q, alu_result_m_d;
    logic [XLEN-1:0] write_data_m_q, write_data_m_d;
    logic [XLEN-1:0] pc_plus4_m_q, pc_plus4_m_d;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] alu_result_e;
    logic            busy;

    // Forwarding muxes
    always_comb begin
        case (forward_a_e)
            2'b01:   src_a = result_w;
            2'b10:   src_a = alu_result_m_q;
            default: src_a = rd1_e;
        endcase
        case (forward_b_e)
            2'b01:   src_b_fwd = result_w;
            2'b10:   src_b_fwd = alu_result_m_q;
            default: src_b_fwd = rd2_e;
        endcase
    end

    assign src_b = alu_src_e ? imm_ext_e : src_b_fwd;
    assign shamt = src_b[SHW-1:0];

    // Combinational ALU; MDU opcodes fall through to 0 here
    always_comb begin
        alu_out = '0;
        case (alu_control_e)
            4'd0:    alu_out = src_a + src_b;
            4'd1:    alu_out = src_a - src_b;
            4'd2:    alu_out = src_a & src_b;
            4'd3:    alu_out = src_a | src_b;
            4'd4:    alu_out = src_a ^ src_b;
            4'd5:    alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'd6:    alu_out = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'd7:    alu_out = src_a << shamt;
            4'd8:    alu_out = src_a >> shamt;
            4'd9:    alu_out = $unsigned($signed(src_a) >>> shamt);
            default: alu_out = '0;
        endcase
    end

    // Branch and jump resolution
    logic            br_eq, br_lt, br_ltu, br_cond;
    logic [XLEN-1:0] jalr_sum;

    assign br_eq  = (src_a == src_b_fwd);
    assign br_lt  = ($signed(src_a) < $signed(src_b_fwd));
    assign br_ltu = (src_a < src_b_fwd);

    always_comb begin
        case (funct3_e)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = !br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = !br_lt;
            3'b110:  br_cond = br_ltu;
            3'b111:  br_cond = !br_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign jalr_sum    = src_a + imm_ext_e;
    assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_ext_e);
    // A stalled instruction must not redirect fetch until its result is ready
    assign pc_src_e    = !busy && ((branch_e && br_cond) || jump_e || jalr_e);

`ifdef EXEC_MDU_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } mdu_state_t;

    mdu_state_t        state_q, state_d;
    logic [1:0]        op_q, op_d;          // 0 MUL, 1 MULH, 2 DIV, 3 REM
    logic [XLEN-1:0]   op_a_q, op_a_d;
    logic [XLEN-1:0]   op_b_q, op_b_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   div_res_q, div_res_d;
    logic [2*XLEN-1:0] prod_q, prod_d;

    logic              is_mdu_op;
    logic [3:0]        mdu_idx;
    logic [XLEN-1:0]   src_a_mag, dvs_mag;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   quo_next, rem_next;
    logic [XLEN-1:0]   q_fix, r_fix;
    logic [2*XLEN-1:0] a_ext, b_ext;
    logic [XLEN-1:0]   mdu_res;
    logic              a_neg, b_neg;

    assign is_mdu_op = (alu_control_e >= 4'd10) && (alu_control_e <= 4'd13);
    assign mdu_idx   = alu_control_e - 4'd10;

    assign a_neg     = op_a_q[XLEN-1];
    assign b_neg     = op_b_q[XLEN-1];
    assign src_a_mag = src_a[XLEN-1] ? -src_a : src_a;
    assign dvs_mag   = b_neg ? -op_b_q : op_b_q;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. The dividend lives in
    // quo_q and is shifted out as quotient bits are shifted in.
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, dvs_mag};
    assign quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign rem_next = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

    // Sign fix-up applied on the final iteration
    always_comb begin
        if (op_b_q == '0) begin
            q_fix = '1;
            r_fix = op_a_q;
        end else if ((op_a_q == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_q == '1)) begin
            q_fix = op_a_q;
            r_fix = '0;
        end else begin
            q_fix = (a_neg ^ b_neg) ? -quo_next : quo_next;
            r_fix = a_neg ? -rem_next : rem_next;
        end
    end

    // Sign-extended operands: the low 2*XLEN bits of their product are the signed product
    assign a_ext = {{XLEN{op_a_q[XLEN-1]}}, op_a_q};
    assign b_ext = {{XLEN{op_b_q[XLEN-1]}}, op_b_q};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div_res_d = div_res_q;
        prod_d    = prod_q;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mdu_op) begin
                    busy    = 1'b1;
                    op_d    = mdu_idx[1:0];
                    op_a_d  = src_a;
                    op_b_d  = src_b;
                    quo_d   = src_a_mag;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = mdu_idx[1] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                busy    = 1'b1;
                prod_d  = a_ext * b_ext;
                state_d = S_DONE;
            end
            S_DIV: begin
                busy  = 1'b1;
                quo_d = quo_next;
                rem_d = rem_next;
                if (cnt_q == CNTW'(XLEN - 1)) begin
                    cnt_d     = '0;
                    div_res_d = op_q[0] ? r_fix : q_fix;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        case (op_q)
            2'd0:    mdu_res = prod_q[XLEN-1:0];
            2'd1:    mdu_res = prod_q[2*XLEN-1:XLEN];
            default: mdu_res = div_res_q;
        endcase
    end

    assign alu_result_e = (state_q == S_DONE) ? mdu_res : alu_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            div_res_q <= '0;
            prod_q    <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_res_q <= div_res_d;
            prod_q    <= prod_d;
        end
    end
`else
    assign busy         = 1'b0;
    assign alu_result_e = alu_out;
`endif

    assign busy_o = busy;

    // E->M next state: a bubble while the MDU stalls the stage
    always_comb begin
        reg_write_m_d  = 1'b0;
        mem_write_m_d  = 1'b0;
        result_src_m_d = '0;
        rd_m_d         = '0;
        alu_result_m_d = '0;
        write_data_m_d = '0;
        pc_plus4_m_d   = '0;
        if (!busy) begin
            reg_write_m_d  = reg_write_e;
            mem_write_m_d  = mem_write_e;
            result_src_m_d = result_src_e;
            rd_m_d         = rd_e;
            alu_result_m_d = alu_result_e;
            write_data_m_d = src_b_fwd;
            pc_plus4_m_d   = pc_plus4_e;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            rd_m_q         <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            rd_m_q         <= rd_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
        end
    end

    assign reg_write_m  = reg_write_m_q;
    assign mem_write_m  = mem_write_m_q;
    assign result_src_m = result_src_m_q;
    assign rd_m         = rd_m_q;
    assign alu_result_m = alu_result_m_q;
    assign write_data_m = write_data_m_q;
    assign pc_plus4_m   = pc_plus4_m_q;

endmodule

// File: tb/tb_execute_stage_mdu.sv
// tb/tb_execute_stage_mdu.sv - directed-vector bench for execute_stage_mdu
module tb_execute_stage_mdu;

`ifdef EXEC_MDU_EN
    localparam bit HAS_MDU = 1'b1;
`else
    localparam bit HAS_MDU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, alu_src_e;
    logic [1:0]  result_src_e;
    logic [3:0]  alu_control_e;
    logic [2:0]  funct3_e;
    logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]  rd_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [31:0] result_w;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic        busy_o;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m, write_data_m, pc_plus4_m;

    int n_vec = 0;
    int n_err = 0;

    execute_stage_mdu #(.XLEN(32), .REGW(5)) dut (
        .clk(clk), .rst(rst),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .branch_e(branch_e),
        .jump_e(jump_e), .jalr_e(jalr_e), .alu_src_e(alu_src_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e), .funct3_e(funct3_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e), .pc_e(pc_e),
        .pc_plus4_e(pc_plus4_e), .rd_e(rd_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .result_w(result_w), .pc_src_e(pc_src_e),
        .pc_target_e(pc_target_e), .busy_o(busy_o), .reg_write_m(reg_write_m),
        .mem_write_m(mem_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reg_write_e = 0; mem_write_e = 0; branch_e = 0; jump_e = 0; jalr_e = 0;
        alu_src_e = 0; result_src_e = 0; alu_control_e = 0; funct3_e = 0;
        rd1_e = 0; rd2_e = 0; imm_ext_e = 0; pc_e = 0; pc_plus4_e = 0; rd_e = 0;
        forward_a_e = 0; forward_b_e = 0; result_w = 0;
    endtask

    // Holds an MDU op in E until the stall releases, then clocks it into M.
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int busy_cyc, output int bub_err);
        busy_cyc = 0;
        bub_err  = 0;
        alu_control_e = op; rd1_e = a; rd2_e = b; alu_src_e = 0;
        forward_a_e = 0; forward_b_e = 0;
        reg_write_e = 1; rd_e = 5'd9; pc_plus4_e = 32'h204; result_src_e = 2'b01;
        #1;
        while (busy_o === 1'b1 && busy_cyc < 100) begin
            busy_cyc++;
            step();
            // Forward sources may move during the stall; only rd1 changes so
            // the data written to M (src_b_fwd) is still predictable.
            rd1_e = 32'hDEAD_BEEF;
            if (reg_write_m !== 0 || mem_write_m !== 0 || rd_m !== 0 || result_src_m !== 0 ||
                alu_result_m !== 0 || write_data_m !== 0 || pc_plus4_m !== 0)
                bub_err++;
        end
        step();
        res = alu_result_m;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        step(); step();
        n_vec++;
        if ({reg_write_m, mem_write_m, result_src_m, rd_m} !== 9'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %h expected 0", {reg_write_m, mem_write_m, result_src_m, rd_m});
        end
        n_vec++;
        if ({alu_result_m, write_data_m, pc_plus4_m} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h expected 0", {alu_result_m, write_data_m, pc_plus4_m});
        end
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        rst = 0;
    endtask

    task automatic test_add();
        clear_inputs();
        rd1_e = 5; rd2_e = 7; reg_write_e = 1; rd_e = 5'd3; pc_plus4_e = 32'h44; result_src_e = 2'b10;
        step();
        n_vec++;
        if (alu_result_m !== 32'd12) begin
            n_err++; $display("FAIL add_result: got %h expected %h", alu_result_m, 32'd12);
        end
        n_vec++;
        if ({reg_write_m, rd_m, result_src_m, write_data_m, pc_plus4_m} !== {1'b1, 5'd3, 2'b10, 32'd7, 32'h44}) begin
            n_err++; $display("FAIL add_fields: got %b/%h/%b/%h/%h expected 1/03/10/7/44",
                              reg_write_m, rd_m, result_src_m, write_data_m, pc_plus4_m);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        rd1_e = 32'h100; reg_write_e = 1;
        step();
        forward_a_e = 2'b10; rd1_e = 32'h5555; alu_src_e = 1; imm_ext_e = 4;
        step();
        n_vec++;
        if (alu_result_m !== 32'h104) begin
            n_err++; $display("FAIL fwd_from_m: got %h expected %h", alu_result_m, 32'h104);
        end
        forward_a_e = 2'b01; result_w = 3;
        step();
        n_vec++;
        if (alu_result_m !== 32'd7) begin
            n_err++; $display("FAIL fwd_from_w: got %h expected %h", alu_result_m, 32'd7);
        end
        forward_a_e = 2'b00; rd1_e = 1; alu_src_e = 0; forward_b_e = 2'b10; rd2_e = 32'h999;
        step();
        n_vec++;
        if ({alu_result_m, write_data_m} !== {32'd8, 32'd7}) begin
            n_err++; $display("FAIL fwd_b_from_m: got %h/%h expected 8/7", alu_result_m, write_data_m);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [9]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
        logic [31:0] av  [9]  = '{32'd5, 32'hF0F0, 32'hF000, 32'hFF00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd1, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv  [9]  = '{32'd7, 32'hFF00, 32'h000F, 32'h0FF0, 32'd1, 32'd1,
                                  32'd33, 32'd4, 32'd4};
        logic [31:0] ev  [9]  = '{32'hFFFF_FFFE, 32'hF000, 32'hF00F, 32'hF0F0, 32'd1, 32'd0,
                                  32'd2, 32'h0800_0000, 32'hF800_0000};
        clear_inputs();
        for (int i = 0; i < 9; i++) begin
            alu_control_e = ops[i]; rd1_e = av[i]; rd2_e = bv[i];
            step();
            n_vec++;
            if (alu_result_m !== ev[i]) begin
                n_err++; $display("FAIL alu_op%0d: got %h expected %h", ops[i], alu_result_m, ev[i]);
            end
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        branch_e = 1; funct3_e = 3'b100; rd1_e = 32'hFFFF_FFFF; rd2_e = 1;
        pc_e = 32'h1000; imm_ext_e = 32'h20;
        #1;
        n_vec++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h1020}) begin
            n_err++; $display("FAIL blt: got %b/%h expected 1/00001020", pc_src_e, pc_target_e);
        end
        funct3_e = 3'b110;
        #1;
        n_vec++;
        if (pc_src_e !== 1'b0) begin
            n_err++; $display("FAIL bltu: got %b expected 0", pc_src_e);
        end
        funct3_e = 3'b000; rd1_e = 32'h77; rd2_e = 32'h77;
        #1;
        n_vec++;
        if (pc_src_e !== 1'b1) begin
            n_err++; $display("FAIL beq_taken: got %b expected 1", pc_src_e);
        end
        funct3_e = 3'b001;
        #1;
        n_vec++;
        if (pc_src_e !== 1'b0) begin
            n_err++; $display("FAIL bne_not_taken: got %b expected 0", pc_src_e);
        end
        branch_e = 0; jalr_e = 1; rd1_e = 32'h1003; imm_ext_e = 0;
        #1;
        n_vec++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h1002}) begin
            n_err++; $display("FAIL jalr: got %b/%h expected 1/00001002", pc_src_e, pc_target_e);
        end
        jalr_e = 0; jump_e = 1; imm_ext_e = 32'hFFFF_FFF0;
        #1;
        n_vec++;
        if ({pc_src_e, pc_target_e} !== {1'b1, 32'h0FF0}) begin
            n_err++; $display("FAIL jal: got %b/%h expected 1/00000ff0", pc_src_e, pc_target_e);
        end
        step();
    endtask

    task automatic test_div();
        logic [31:0] res;
        int bc, be;
        clear_inputs();
        run_mdu(4'd12, 32'hFFFF_FFF9, 32'd2, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'hFFFF_FFFD : 32'd0)) begin
            n_err++; $display("FAIL div_result: got %h expected %h", res, HAS_MDU ? 32'hFFFF_FFFD : 32'd0);
        end
        n_vec++;
        if (bc !== (HAS_MDU ? 33 : 0)) begin
            n_err++; $display("FAIL div_busy_cycles: got %0d expected %0d", bc, HAS_MDU ? 33 : 0);
        end
        n_vec++;
        if (be !== 0) begin
            n_err++; $display("FAIL div_bubbles: got %0d non-bubble cycles expected 0", be);
        end
        n_vec++;
        if ({reg_write_m, rd_m, result_src_m, write_data_m, pc_plus4_m} !== {1'b1, 5'd9, 2'b01, 32'd2, 32'h204}) begin
            n_err++; $display("FAIL div_fields: got %b/%h/%b/%h/%h expected 1/09/01/2/204",
                              reg_write_m, rd_m, result_src_m, write_data_m, pc_plus4_m);
        end
        run_mdu(4'd13, 32'hFFFF_FFF9, 32'd2, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'hFFFF_FFFF : 32'd0)) begin
            n_err++; $display("FAIL rem_result: got %h expected %h", res, HAS_MDU ? 32'hFFFF_FFFF : 32'd0);
        end
        run_mdu(4'd12, 32'd1234, 32'd0, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'hFFFF_FFFF : 32'd0)) begin
            n_err++; $display("FAIL div_by_zero: got %h expected %h", res, HAS_MDU ? 32'hFFFF_FFFF : 32'd0);
        end
        run_mdu(4'd13, 32'd1234, 32'd0, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'd1234 : 32'd0)) begin
            n_err++; $display("FAIL rem_by_zero: got %h expected %h", res, HAS_MDU ? 32'd1234 : 32'd0);
        end
        run_mdu(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'h8000_0000 : 32'd0)) begin
            n_err++; $display("FAIL div_overflow: got %h expected %h", res, HAS_MDU ? 32'h8000_0000 : 32'd0);
        end
        run_mdu(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, res, bc, be);
        n_vec++;
        if (res !== 32'd0) begin
            n_err++; $display("FAIL rem_overflow: got %h expected 0", res);
        end
        run_mdu(4'd13, 32'd100, 32'hFFFF_FFF9, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'd2 : 32'd0)) begin
            n_err++; $display("FAIL rem_pos_neg: got %h expected %h", res, HAS_MDU ? 32'd2 : 32'd0);
        end
        clear_inputs();
    endtask

    task automatic test_mul();
        logic [31:0] res;
        int bc, be;
        clear_inputs();
        branch_e = 1; funct3_e = 3'b000;
        alu_control_e = 4'd11; rd1_e = 32'h8000_0000; rd2_e = 32'h8000_0000;
        #1;
        n_vec++;
        if (pc_src_e !== (HAS_MDU ? 1'b0 : 1'b1)) begin
            n_err++; $display("FAIL branch_gated_by_busy: got %b expected %b", pc_src_e, HAS_MDU ? 1'b0 : 1'b1);
        end
        run_mdu(4'd11, 32'h8000_0000, 32'h8000_0000, res, bc, be);
        branch_e = 0;
        n_vec++;
        if (res !== (HAS_MDU ? 32'h4000_0000 : 32'd0)) begin
            n_err++; $display("FAIL mulh_result: got %h expected %h", res, HAS_MDU ? 32'h4000_0000 : 32'd0);
        end
        n_vec++;
        if (bc !== (HAS_MDU ? 2 : 0) || be !== 0) begin
            n_err++; $display("FAIL mulh_busy: got %0d cycles/%0d bad bubbles expected %0d/0", bc, be, HAS_MDU ? 2 : 0);
        end
        run_mdu(4'd10, 32'hFFFF_FFFF, 32'd2, res, bc, be);
        n_vec++;
        if (res !== (HAS_MDU ? 32'hFFFF_FFFE : 32'd0)) begin
            n_err++; $display("FAIL mul_result: got %h expected %h", res, HAS_MDU ? 32'hFFFF_FFFE : 32'd0);
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int bc1, bc2, be;
        clear_inputs();
        run_mdu(4'd10, 32'd6, 32'd7, r1, bc1, be);
        run_mdu(4'd12, 32'd100, 32'd7, r2, bc2, be);
        n_vec++;
        if ({r1, r2} !== (HAS_MDU ? {32'd42, 32'd14} : 64'd0)) begin
            n_err++; $display("FAIL b2b_results: got %h/%h expected %h/%h", r1, r2,
                              HAS_MDU ? 32'd42 : 32'd0, HAS_MDU ? 32'd14 : 32'd0);
        end
        n_vec++;
        if (bc1 !== (HAS_MDU ? 2 : 0) || bc2 !== (HAS_MDU ? 33 : 0)) begin
            n_err++; $display("FAIL b2b_busy: got %0d/%0d expected %0d/%0d", bc1, bc2,
                              HAS_MDU ? 2 : 0, HAS_MDU ? 33 : 0);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_div();
        clear_inputs();
        alu_control_e = 4'd12; rd1_e = 32'd1000; rd2_e = 32'd3; reg_write_e = 1; rd_e = 5'd4;
        pc_plus4_e = 32'h88;
        for (int i = 0; i < 10; i++) step();
        n_vec++;
        if (busy_o !== HAS_MDU) begin
            n_err++; $display("FAIL mid_div_busy: got %b expected %b", busy_o, HAS_MDU);
        end
        // Pipeline-wide reset: E becomes a bubble alongside this block's reset
        clear_inputs();
        rst = 1;
        step();
        n_vec++;
        if ({busy_o, reg_write_m, mem_write_m, result_src_m, rd_m, alu_result_m, write_data_m, pc_plus4_m} !== 106'd0) begin
            n_err++; $display("FAIL reset_mid_div: got busy %b rw %b rd %h res %h wd %h pc4 %h expected all 0",
                              busy_o, reg_write_m, rd_m, alu_result_m, write_data_m, pc_plus4_m);
        end
        rst = 0;
        rd1_e = 5; rd2_e = 7; reg_write_e = 1; rd_e = 5'd2;
        #1;
        n_vec++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL post_reset_busy: got %b expected 0", busy_o);
        end
        step();
        n_vec++;
        if ({alu_result_m, rd_m, reg_write_m} !== {32'd12, 5'd2, 1'b1}) begin
            n_err++; $display("FAIL post_reset_add: got %h/%h/%b expected 0000000c/02/1", alu_result_m, rd_m, reg_write_m);
        end
        // FSM must be back in IDLE and able to run a full op
        begin
            logic [31:0] res;
            int bc, be;
            run_mdu(4'd10, 32'd3, 32'd5, res, bc, be);
            n_vec++;
            if (res !== (HAS_MDU ? 32'd15 : 32'd0)) begin
                n_err++; $display("FAIL post_reset_mul: got %h expected %h", res, HAS_MDU ? 32'd15 : 32'd0);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_alu_ops();
        test_branch();
        test_div();
        test_mul();
        test_back_to_back();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
